// File: rtl/regfile_pkg.sv
// Shared widths, register-file constants and arbiter state type for the
// register-file writeback arbiter.
package regfile_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned NUM_REGS   = 32;

    localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;

    typedef enum logic {
        PRI_A = 1'b0,
        PRI_B = 1'b1
    } arbState_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter; req[0]/gnt[0] is requester A, req[1]/gnt[1] is B.
// Grants are combinational; the priority state advances on every grant.
module rr_arbiter2
    import regfile_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    arbState_e state;
    arbState_e stateNext;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= PRI_A;
        end else begin
            state <= stateNext;
        end
    end

    // Favoured requester wins contention; a lone requester always wins.
    always_comb begin
        gnt       = 2'b00;
        stateNext = state;
        case (state)
            PRI_B: begin
                if (req[1]) begin
                    gnt = 2'b10;
                end else if (req[0]) begin
                    gnt = 2'b01;
                end
            end
            default: begin
                if (req[0]) begin
                    gnt = 2'b01;
                end else if (req[1]) begin
                    gnt = 2'b10;
                end
            end
        endcase
        if (gnt[0]) begin
            stateNext = PRI_B;
        end else if (gnt[1]) begin
            stateNext = PRI_A;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter with a pending-result scoreboard.
// Optional same-cycle bypass of the committing write: define REGFILE_WB_BYPASS_EN.
module regfile_wb_arbiter
    import regfile_pkg::REG_ADDR_W;
    import regfile_pkg::ZERO_REG;
#(
    parameter int unsigned N        = 32,
    parameter int unsigned NUM_REGS = regfile_pkg::NUM_REGS
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  a_valid,
    output logic                  a_ready,
    input  logic [REG_ADDR_W-1:0] a_reg,
    input  logic [N-1:0]          a_data,

    input  logic                  b_valid,
    output logic                  b_ready,
    input  logic [REG_ADDR_W-1:0] b_reg,
    input  logic [N-1:0]          b_data,

    output logic                  RegWrite,
    output logic [REG_ADDR_W-1:0] WriteRegister,
    output logic [N-1:0]          WriteData,

    input  logic                  sb_set,
    input  logic [REG_ADDR_W-1:0] sb_reg,

    input  logic [REG_ADDR_W-1:0] chk_reg1,
    input  logic [REG_ADDR_W-1:0] chk_reg2,
    output logic                  hazard1,
    output logic                  hazard2,

    output logic                  byp_hit1,
    output logic                  byp_hit2,
    output logic [N-1:0]          byp_data1,
    output logic [N-1:0]          byp_data2
);

    logic [1:0]          gnt;
    logic                aFire;
    logic                bFire;
    logic [NUM_REGS-1:1] busy;
    logic [NUM_REGS-1:0] busyAll;

    // Requests are masked during reset so nothing can handshake then.
    rr_arbiter2 uArb (
        .clk (clk),
        .rst (rst),
        .req ({b_valid & ~rst, a_valid & ~rst}),
        .gnt (gnt)
    );

    assign aFire   = gnt[0];
    assign bFire   = gnt[1];
    assign a_ready = aFire;
    assign b_ready = bFire;

    // Write port: one cycle after the handshake; register 0 is swallowed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            RegWrite      <= 1'b0;
            WriteRegister <= '0;
            WriteData     <= '0;
        end else if (aFire) begin
            RegWrite      <= (a_reg != ZERO_REG);
            WriteRegister <= a_reg;
            WriteData     <= a_data;
        end else if (bFire) begin
            RegWrite      <= (b_reg != ZERO_REG);
            WriteRegister <= b_reg;
            WriteData     <= b_data;
        end else begin
            RegWrite      <= 1'b0;
        end
    end

    // Busy bits: a new pending mark beats the B result clearing the same register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= '0;
        end else begin
            for (int unsigned i = 1; i < NUM_REGS; i++) begin
                if (sb_set && (sb_reg == REG_ADDR_W'(i))) begin
                    busy[i] <= 1'b1;
                end else if (bFire && (b_reg == REG_ADDR_W'(i))) begin
                    busy[i] <= 1'b0;
                end
            end
        end
    end

    assign busyAll = {busy, 1'b0};
    assign hazard1 = busyAll[chk_reg1];
    assign hazard2 = busyAll[chk_reg2];

`ifdef REGFILE_WB_BYPASS_EN
    assign byp_hit1  = RegWrite && (WriteRegister == chk_reg1) && (chk_reg1 != ZERO_REG);
    assign byp_hit2  = RegWrite && (WriteRegister == chk_reg2) && (chk_reg2 != ZERO_REG);
    assign byp_data1 = WriteData;
    assign byp_data2 = WriteData;
`else
    assign byp_hit1  = 1'b0;
    assign byp_hit2  = 1'b0;
    assign byp_data1 = '0;
    assign byp_data2 = '0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed vector table, hand-written reset and
// round-robin sequences, then random traffic against a behavioural model.
module tb_regfile_wb_arbiter;

    localparam int unsigned N = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_valid, a_ready, b_valid, b_ready;
    logic [4:0]  a_reg, b_reg;
    logic [31:0] a_data, b_data;
    logic        RegWrite;
    logic [4:0]  WriteRegister;
    logic [31:0] WriteData;
    logic        sb_set;
    logic [4:0]  sb_reg, chk_reg1, chk_reg2;
    logic        hazard1, hazard2, byp_hit1, byp_hit2;
    logic [31:0] byp_data1, byp_data2;

    always #5 clk = ~clk;

    regfile_wb_arbiter #(.N(N), .NUM_REGS(32)) dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_ready(a_ready), .a_reg(a_reg), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_reg(b_reg), .b_data(b_data),
        .RegWrite(RegWrite), .WriteRegister(WriteRegister), .WriteData(WriteData),
        .sb_set(sb_set), .sb_reg(sb_reg),
        .chk_reg1(chk_reg1), .chk_reg2(chk_reg2),
        .hazard1(hazard1), .hazard2(hazard2),
        .byp_hit1(byp_hit1), .byp_hit2(byp_hit2),
        .byp_data1(byp_data1), .byp_data2(byp_data2)
    );

    typedef struct {
        logic        aV;
        logic [4:0]  aReg;
        logic [31:0] aData;
        logic        bV;
        logic [4:0]  bReg;
        logic [31:0] bData;
        logic        sbSet;
        logic [4:0]  sbReg;
        logic [4:0]  c1;
        logic [4:0]  c2;
        logic        eA;
        logic        eB;
        logic        eRW;
        logic        eChkW;
        logic [4:0]  eWR;
        logic [31:0] eWD;
        logic        eH1;
        logic        eH2;
    } vec_t;

    int nCmp = 0;
    int nMis = 0;

    // Reference model: who was granted last, which registers await B, last committed write.
    bit          mLastB;
    bit          mBusy [32];
    bit          mRW;
    logic [4:0]  mWR;
    logic [31:0] mWD;

    task automatic chk(input string tag, input string nm, input logic [63:0] act, input logic [63:0] exp);
        nCmp++;
        if (act !== exp) begin
            nMis++;
            $display("FAIL %s.%s: got %0h expected %0h", tag, nm, act, exp);
        end
    endtask

    task automatic mReset();
        mLastB = 1'b1;
        mRW    = 1'b0;
        mWR    = '0;
        mWD    = '0;
        for (int i = 0; i < 32; i++) mBusy[i] = 1'b0;
    endtask

    task automatic apply(input vec_t v);
        a_valid  = v.aV;   a_reg  = v.aReg;  a_data = v.aData;
        b_valid  = v.bV;   b_reg  = v.bReg;  b_data = v.bData;
        sb_set   = v.sbSet; sb_reg = v.sbReg;
        chk_reg1 = v.c1;   chk_reg2 = v.c2;
    endtask

    task automatic compareExp(input string tag, input logic eA, input logic eB, input logic eRW,
                              input logic eChkW, input logic [4:0] eWR, input logic [31:0] eWD,
                              input logic eH1, input logic eH2, input logic [4:0] c1, input logic [4:0] c2);
        logic h1, h2;
        chk(tag, "a_ready", a_ready, eA);
        chk(tag, "b_ready", b_ready, eB);
        chk(tag, "RegWrite", RegWrite, eRW);
        if (eChkW) begin
            chk(tag, "WriteRegister", WriteRegister, eWR);
            chk(tag, "WriteData", WriteData, eWD);
        end
        chk(tag, "hazard1", hazard1, eH1);
        chk(tag, "hazard2", hazard2, eH2);
`ifdef REGFILE_WB_BYPASS_EN
        h1 = eRW && (eWR == c1) && (c1 != 5'd0);
        h2 = eRW && (eWR == c2) && (c2 != 5'd0);
        chk(tag, "byp_hit1", byp_hit1, h1);
        chk(tag, "byp_hit2", byp_hit2, h2);
        if (h1) chk(tag, "byp_data1", byp_data1, eWD);
        if (h2) chk(tag, "byp_data2", byp_data2, eWD);
`else
        h1 = 1'b0;
        h2 = 1'b0;
        chk(tag, "byp_hit1", byp_hit1, h1);
        chk(tag, "byp_hit2", byp_hit2, h2);
        chk(tag, "byp_data1", byp_data1, 32'd0);
        chk(tag, "byp_data2", byp_data2, 32'd0);
`endif
    endtask

    // One clock: drive at the falling edge, check, then advance the model across the rising edge.
    task automatic runCycle(input vec_t v, input bit useTable, input string tag);
        bit gA, gB;
        @(negedge clk);
        apply(v);
        #1;
        gA = 1'b0;
        gB = 1'b0;
        if (v.aV && v.bV) begin
            if (mLastB) gA = 1'b1; else gB = 1'b1;
        end else if (v.aV) begin
            gA = 1'b1;
        end else if (v.bV) begin
            gB = 1'b1;
        end
        if (useTable)
            compareExp(tag, v.eA, v.eB, v.eRW, v.eChkW, v.eWR, v.eWD, v.eH1, v.eH2, v.c1, v.c2);
        else
            compareExp(tag, gA, gB, mRW, mRW, mWR, mWD, mBusy[v.c1], mBusy[v.c2], v.c1, v.c2);
        if (gA) begin
            mLastB = 1'b0;
            mRW    = (v.aReg != 5'd0);
            if (mRW) begin mWR = v.aReg; mWD = v.aData; end
        end else if (gB) begin
            mLastB = 1'b1;
            mRW    = (v.bReg != 5'd0);
            if (mRW) begin mWR = v.bReg; mWD = v.bData; end
            mBusy[v.bReg] = 1'b0;
        end else begin
            mRW = 1'b0;
        end
        if (v.sbSet && v.sbReg != 5'd0) mBusy[v.sbReg] = 1'b1;
        mBusy[0] = 1'b0;
    endtask

    task automatic doReset(input string tag);
        vec_t idle = '{default: '0};
        @(negedge clk);
        rst = 1'b1;
        apply(idle);
        a_valid = 1'b1;
        b_valid = 1'b1;
        #1;
        chk(tag, "a_ready", a_ready, 1'b0);
        chk(tag, "b_ready", b_ready, 1'b0);
        chk(tag, "RegWrite", RegWrite, 1'b0);
        chk(tag, "WriteRegister", WriteRegister, 5'd0);
        chk(tag, "WriteData", WriteData, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        apply(idle);
        mReset();
    endtask

    vec_t tbl [15];
    vec_t v;

    initial begin
        vec_t idle = '{default: '0};
        rst = 1'b1;
        apply(idle);
        mReset();

        //              aV    aReg   aData          bV    bReg   bData      sb    sbReg  c1     c2      eA    eB    eRW   eChkW eWR    eWD            eH1   eH2
        tbl[0]  = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0,  32'h0,     1'b0, 5'd0,  5'd0,  5'd0,   1'b1, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 1'b0};
        tbl[1]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,     1'b0, 5'd0,  5'd5,  5'd0,   1'b0, 1'b0, 1'b1, 1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 5'd3,  32'h33,       1'b1, 5'd7,  32'h77,    1'b0, 5'd0,  5'd0,  5'd0,   1'b0, 1'b1, 1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 1'b0};
        tbl[3]  = '{1'b1, 5'd3,  32'h33,       1'b1, 5'd7,  32'h77,    1'b0, 5'd0,  5'd0,  5'd0,   1'b1, 1'b0, 1'b1, 1'b1, 5'd7,  32'h77,       1'b0, 1'b0};
        tbl[4]  = '{1'b1, 5'd3,  32'h33,       1'b1, 5'd7,  32'h77,    1'b0, 5'd0,  5'd0,  5'd0,   1'b0, 1'b1, 1'b1, 1'b1, 5'd3,  32'h33,       1'b0, 1'b0};
        tbl[5]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,     1'b0, 5'd0,  5'd0,  5'd0,   1'b0, 1'b0, 1'b1, 1'b1, 5'd7,  32'h77,       1'b0, 1'b0};
        tbl[6]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,     1'b0, 5'd0,  5'd0,  5'd0,   1'b0, 1'b0, 1'b0, 1'b1, 5'd7,  32'h77,       1'b0, 1'b0};
        tbl[7]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,     1'b1, 5'd9,  5'd9,  5'd0,   1'b0, 1'b0, 1'b0, 1'b1, 5'd7,  32'h77,       1'b0, 1'b0};
        tbl[8]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd9,  32'h99,    1'b0, 5'd0,  5'd9,  5'd0,   1'b0, 1'b1, 1'b0, 1'b1, 5'd7,  32'h77,       1'b1, 1'b0};
        tbl[9]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd9,  32'h98,    1'b1, 5'd9,  5'd9,  5'd0,   1'b0, 1'b1, 1'b1, 1'b1, 5'd9,  32'h99,       1'b0, 1'b0};
        tbl[10] = '{1'b1, 5'd0,  32'h1234,     1'b0, 5'd0,  32'h0,     1'b1, 5'd0,  5'd9,  5'd0,   1'b1, 1'b0, 1'b1, 1'b1, 5'd9,  32'h98,       1'b1, 1'b0};
        tbl[11] = '{1'b1, 5'd3,  32'h33,       1'b1, 5'd7,  32'h77,    1'b0, 5'd0,  5'd0,  5'd9,   1'b0, 1'b1, 1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 1'b1};
        tbl[12] = '{1'b1, 5'd12, 32'hCAFE0000, 1'b0, 5'd0,  32'h0,     1'b0, 5'd0,  5'd0,  5'd7,   1'b1, 1'b0, 1'b1, 1'b1, 5'd7,  32'h77,       1'b0, 1'b0};
        tbl[13] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,     1'b0, 5'd0,  5'd0,  5'd12,  1'b0, 1'b0, 1'b1, 1'b1, 5'd12, 32'hCAFE0000, 1'b0, 1'b0};
        tbl[14] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,     1'b0, 5'd0,  5'd0,  5'd12,  1'b0, 1'b0, 1'b0, 1'b1, 5'd12, 32'hCAFE0000, 1'b0, 1'b0};

        doReset("reset");
        for (int i = 0; i < 15; i++) runCycle(tbl[i], 1'b1, $sformatf("vec%0d", i));

        // Contention straight after reset alternates A, B, A, B.
        doReset("reset2");
        for (int i = 0; i < 4; i++) begin
            v = '{default: '0};
            v.aV = 1'b1; v.aReg = 5'd3; v.aData = 32'hA0 + 32'(i);
            v.bV = 1'b1; v.bReg = 5'd7; v.bData = 32'hB0 + 32'(i);
            runCycle(v, 1'b0, $sformatf("rr%0d", i));
            chk("rr_order", "a_ready", a_ready, (i % 2 == 0) ? 1'b1 : 1'b0);
        end
        runCycle(idle, 1'b0, "rr_tail");

        // Reset mid-stream: busy[4] set and a handshake in flight are both dropped.
        v = '{default: '0};
        v.sbSet = 1'b1; v.sbReg = 5'd4;
        runCycle(v, 1'b0, "midrst_set");
        v = '{default: '0};
        v.aV = 1'b1; v.aReg = 5'd6; v.aData = 32'h66; v.c1 = 5'd4;
        runCycle(v, 1'b0, "midrst_wr");
        @(posedge clk);
        #2;
        chk("midrst_pre", "RegWrite", RegWrite, 1'b1);
        rst = 1'b1;
        #1;
        chk("midrst", "RegWrite", RegWrite, 1'b0);
        chk("midrst", "hazard1", hazard1, 1'b0);
        chk("midrst", "a_ready", a_ready, 1'b0);
        chk("midrst", "WriteRegister", WriteRegister, 5'd0);
        @(negedge clk);
        rst = 1'b0;
        apply(idle);
        mReset();
        v = '{default: '0};
        v.c1 = 5'd4;
        runCycle(v, 1'b0, "postrst_idle");
        v.aV = 1'b1; v.aReg = 5'd1; v.aData = 32'h11;
        v.bV = 1'b1; v.bReg = 5'd2; v.bData = 32'h22;
        runCycle(v, 1'b0, "postrst_cont");
        chk("postrst_first", "a_ready", a_ready, 1'b1);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            v = '{default: '0};
            v.aV    = 1'($urandom_range(0, 1));
            v.aReg  = 5'($urandom_range(0, 15));
            v.aData = $urandom;
            v.bV    = 1'($urandom_range(0, 1));
            v.bReg  = 5'($urandom_range(0, 15));
            v.bData = $urandom;
            v.sbSet = ($urandom_range(0, 2) == 0);
            v.sbReg = 5'($urandom_range(0, 15));
            v.c1    = 5'($urandom_range(0, 15));
            v.c2    = 5'($urandom_range(0, 15));
            runCycle(v, 1'b0, $sformatf("rand%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nMis);
        $finish;
    end

endmodule
